// File: rtl/lsu_mm_issue_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mm_issue_ctrl
//
// Purpose:
//   Upstream sequencer for the WRAM and IRAM matmul operand buffers. One matmul
//   command is accepted over a valid/ready handshake and split into
//   tile_num+1 tile operations. For every tile both buffers receive a one-cycle
//   ctrl_vld pulse with that tile's start address. The controller then waits
//   until both buffers have reported mxu_end before it issues the next tile.
//
// Handshake:
//   A command transfers on a rising clk edge where lsu_mm_cmd_vld and
//   lsu_mm_cmd_rdy are both 1. rdy is a pure decode of IDLE and does not depend
//   on vld. The sender holds vld and all command fields stable until the
//   transfer; vld presented outside IDLE is simply not taken.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   lsu_mm_cmd_*                   command handshake and fields
//   lsu_mm_wbuff_ctrl_vld/_addr    WRAM buffer start pulse and tile address
//   lsu_mm_ibuff_ctrl_vld/_addr    IRAM buffer start pulse and tile address
//   lsu_mm_buff_ctrl_row/col_len   latched lengths shared by both buffers
//   lsu_mm_wbuff/ibuff_mxu_end     sticky done flags from the buffers
//   lsu_mm_tile_done/_idx          per-tile completion pulse, tile in flight
//   lsu_mm_cmd_done                pulse when the command finishes or aborts
//   lsu_mm_busy, lsu_mm_err        not-idle status, sticky timeout error
//   lsu_mm_dbg_state               FSM state (0 IDLE, 1 ISSUE, 2 WAIT)
//
// Configuration:
//   LSU_MM_ISSUE_CTRL_TIMEOUT_EN   when defined, a WAIT watchdog of TIMEOUT_CYC
//                                  cycles aborts the command and sets err.
//                                  When undefined, err is 0 and WAIT has no
//                                  time limit.
// -----------------------------------------------------------------------------
module lsu_mm_issue_ctrl #(
   parameter int ADDR_W      = 12,
   parameter int LEN_W       = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lsu_mm_cmd_vld,
   output logic              lsu_mm_cmd_rdy,
   input  logic [ADDR_W-1:0] lsu_mm_cmd_wram_addr,
   input  logic [ADDR_W-1:0] lsu_mm_cmd_iram_addr,
   input  logic [ADDR_W-1:0] lsu_mm_cmd_wram_stride,
   input  logic [ADDR_W-1:0] lsu_mm_cmd_iram_stride,
   input  logic [LEN_W-1:0]  lsu_mm_cmd_row_len,
   input  logic [LEN_W-1:0]  lsu_mm_cmd_col_len,
   input  logic [LEN_W-1:0]  lsu_mm_cmd_tile_num,
   output logic              lsu_mm_wbuff_ctrl_vld,
   output logic [ADDR_W-1:0] lsu_mm_wbuff_ctrl_start_addr,
   output logic              lsu_mm_ibuff_ctrl_vld,
   output logic [ADDR_W-1:0] lsu_mm_ibuff_ctrl_start_addr,
   output logic [LEN_W-1:0]  lsu_mm_buff_ctrl_row_len,
   output logic [LEN_W-1:0]  lsu_mm_buff_ctrl_col_len,
   input  logic              lsu_mm_wbuff_mxu_end,
   input  logic              lsu_mm_ibuff_mxu_end,
   output logic              lsu_mm_tile_done,
   output logic [LEN_W-1:0]  lsu_mm_tile_idx,
   output logic              lsu_mm_cmd_done,
   output logic              lsu_mm_busy,
   output logic              lsu_mm_err,
   output logic [1:0]        lsu_mm_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wram_addr_q, wram_addr_d;
   logic [ADDR_W-1:0] iram_addr_q, iram_addr_d;
   logic [ADDR_W-1:0] wram_stride_q, wram_stride_d;
   logic [ADDR_W-1:0] iram_stride_q, iram_stride_d;
   logic [LEN_W-1:0]  row_len_q, row_len_d;
   logic [LEN_W-1:0]  col_len_q, col_len_d;
   logic [LEN_W-1:0]  tile_num_q, tile_num_d;
   logic [LEN_W-1:0]  tile_idx_q, tile_idx_d;
   logic              w_seen_q, w_seen_d;
   logic              i_seen_q, i_seen_d;
   logic              blank_q, blank_d;
   logic              tile_done;
   logic              cmd_done;
   logic              w_hit, i_hit, both_hit;
   logic              timeout;

   // The first WAIT cycle still sees the previous tile's sticky end flags,
   // because the buffers only clear them off the ctrl_vld pulse. blank_q masks
   // that cycle. An end arriving in the current cycle counts immediately.
   assign w_hit    = w_seen_q | (lsu_mm_wbuff_mxu_end & ~blank_q);
   assign i_hit    = i_seen_q | (lsu_mm_ibuff_mxu_end & ~blank_q);
   assign both_hit = w_hit & i_hit;

`ifdef LSU_MM_ISSUE_CTRL_TIMEOUT_EN
   logic [7:0] wd_cnt_q, wd_cnt_d;
   logic       err_q, err_d;

   // wd_cnt_q holds the number of WAIT cycles already completed. The abort
   // therefore fires during the TIMEOUT_CYC-th WAIT cycle.
   assign timeout = (state_q == ST_WAIT) & ~both_hit &
                    (wd_cnt_q == 8'(TIMEOUT_CYC - 1));

   always_comb begin
      wd_cnt_d = wd_cnt_q;
      err_d    = err_q;
      if (state_q == ST_ISSUE) begin
         wd_cnt_d = 8'd0;
      end else if (state_q == ST_WAIT) begin
         wd_cnt_d = wd_cnt_q + 8'd1;
      end
      if (state_q == ST_IDLE && lsu_mm_cmd_vld) begin
         err_d = 1'b0;
      end else if (timeout) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q <= 8'd0;
         err_q    <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         err_q    <= err_d;
      end
   end

   assign lsu_mm_err = err_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
   assign timeout            = 1'b0;
   assign lsu_mm_err         = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      wram_addr_d   = wram_addr_q;
      iram_addr_d   = iram_addr_q;
      wram_stride_d = wram_stride_q;
      iram_stride_d = iram_stride_q;
      row_len_d     = row_len_q;
      col_len_d     = col_len_q;
      tile_num_d    = tile_num_q;
      tile_idx_d    = tile_idx_q;
      w_seen_d      = w_seen_q;
      i_seen_d      = i_seen_q;
      blank_d       = 1'b0;
      tile_done     = 1'b0;
      cmd_done      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (lsu_mm_cmd_vld) begin
               wram_addr_d   = lsu_mm_cmd_wram_addr;
               iram_addr_d   = lsu_mm_cmd_iram_addr;
               wram_stride_d = lsu_mm_cmd_wram_stride;
               iram_stride_d = lsu_mm_cmd_iram_stride;
               row_len_d     = lsu_mm_cmd_row_len;
               col_len_d     = lsu_mm_cmd_col_len;
               tile_num_d    = lsu_mm_cmd_tile_num;
               tile_idx_d    = '0;
               w_seen_d      = 1'b0;
               i_seen_d      = 1'b0;
               state_d       = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            w_seen_d = 1'b0;
            i_seen_d = 1'b0;
            blank_d  = 1'b1;
            state_d  = ST_WAIT;
         end

         ST_WAIT: begin
            if (both_hit) begin
               tile_done = 1'b1;
               w_seen_d  = 1'b0;
               i_seen_d  = 1'b0;
               if (tile_idx_q == tile_num_q) begin
                  cmd_done = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  // Address arithmetic wraps modulo 2^ADDR_W by design.
                  tile_idx_d  = tile_idx_q + 1'b1;
                  wram_addr_d = wram_addr_q + wram_stride_q;
                  iram_addr_d = iram_addr_q + iram_stride_q;
                  state_d     = ST_ISSUE;
               end
            end else if (timeout) begin
               // Abort: cmd_done without tile_done.
               cmd_done = 1'b1;
               w_seen_d = 1'b0;
               i_seen_d = 1'b0;
               state_d  = ST_IDLE;
            end else begin
               w_seen_d = w_hit;
               i_seen_d = i_hit;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         wram_addr_q   <= '0;
         iram_addr_q   <= '0;
         wram_stride_q <= '0;
         iram_stride_q <= '0;
         row_len_q     <= '0;
         col_len_q     <= '0;
         tile_num_q    <= '0;
         tile_idx_q    <= '0;
         w_seen_q      <= 1'b0;
         i_seen_q      <= 1'b0;
         blank_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         wram_addr_q   <= wram_addr_d;
         iram_addr_q   <= iram_addr_d;
         wram_stride_q <= wram_stride_d;
         iram_stride_q <= iram_stride_d;
         row_len_q     <= row_len_d;
         col_len_q     <= col_len_d;
         tile_num_q    <= tile_num_d;
         tile_idx_q    <= tile_idx_d;
         w_seen_q      <= w_seen_d;
         i_seen_q      <= i_seen_d;
         blank_q       <= blank_d;
      end
   end

   assign lsu_mm_cmd_rdy               = (state_q == ST_IDLE);
   assign lsu_mm_busy                  = (state_q != ST_IDLE);
   assign lsu_mm_wbuff_ctrl_vld        = (state_q == ST_ISSUE);
   assign lsu_mm_ibuff_ctrl_vld        = (state_q == ST_ISSUE);
   assign lsu_mm_wbuff_ctrl_start_addr = wram_addr_q;
   assign lsu_mm_ibuff_ctrl_start_addr = iram_addr_q;
   assign lsu_mm_buff_ctrl_row_len     = row_len_q;
   assign lsu_mm_buff_ctrl_col_len     = col_len_q;
   assign lsu_mm_tile_done             = tile_done;
   assign lsu_mm_cmd_done              = cmd_done;
   assign lsu_mm_tile_idx              = tile_idx_q;
   assign lsu_mm_dbg_state             = state_q;

endmodule

// File: tb/tb_lsu_mm_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mm_issue_ctrl
//
// Directed bench for lsu_mm_issue_ctrl. The driver pushes hand-computed
// expected tile issues and tile completions into queues before each command.
// A negedge monitor pops them whenever the DUT pulses ctrl_vld, tile_done or
// cmd_done. A small buffer model raises each sticky mxu_end a programmable
// number of cycles after ctrl_vld. A latency of 0 means the end never comes.
// -----------------------------------------------------------------------------
module tb_lsu_mm_issue_ctrl;
  localparam int AW = 12;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_vld = 1'b0;
  logic          cmd_rdy;
  logic [AW-1:0] cmd_wa = '0, cmd_ia = '0, cmd_ws = '0, cmd_is = '0;
  logic [LW-1:0] cmd_row = '0, cmd_col = '0, cmd_tn = '0;
  logic          wvld, ivld;
  logic [AW-1:0] waddr, iaddr;
  logic [LW-1:0] row_len, col_len;
  logic          wend = 1'b0, iend = 1'b0;
  logic          tile_done, cmd_done, busy, err;
  logic [LW-1:0] tile_idx;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  lsu_mm_issue_ctrl #(.ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYC(64)) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .lsu_mm_cmd_vld               (cmd_vld),
    .lsu_mm_cmd_rdy               (cmd_rdy),
    .lsu_mm_cmd_wram_addr         (cmd_wa),
    .lsu_mm_cmd_iram_addr         (cmd_ia),
    .lsu_mm_cmd_wram_stride       (cmd_ws),
    .lsu_mm_cmd_iram_stride       (cmd_is),
    .lsu_mm_cmd_row_len           (cmd_row),
    .lsu_mm_cmd_col_len           (cmd_col),
    .lsu_mm_cmd_tile_num          (cmd_tn),
    .lsu_mm_wbuff_ctrl_vld        (wvld),
    .lsu_mm_wbuff_ctrl_start_addr (waddr),
    .lsu_mm_ibuff_ctrl_vld        (ivld),
    .lsu_mm_ibuff_ctrl_start_addr (iaddr),
    .lsu_mm_buff_ctrl_row_len     (row_len),
    .lsu_mm_buff_ctrl_col_len     (col_len),
    .lsu_mm_wbuff_mxu_end         (wend),
    .lsu_mm_ibuff_mxu_end         (iend),
    .lsu_mm_tile_done             (tile_done),
    .lsu_mm_tile_idx              (tile_idx),
    .lsu_mm_cmd_done              (cmd_done),
    .lsu_mm_busy                  (busy),
    .lsu_mm_err                   (err),
    .lsu_mm_dbg_state             (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  // issue item: {waddr[35:24], iaddr[23:12], row[11:8], col[7:4], idx[3:0]}
  logic [35:0] iss_q[$];
  // tile item: {idx[12:9], latency[8:1], last[0]}
  logic [12:0] tile_q[$];
  // timeout item: expected WAIT-cycle latency of the aborting cmd_done
  logic [7:0]  to_q[$];
  int w_lat = 0, i_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_issue(input logic [AW-1:0] wa, input logic [AW-1:0] ia,
                           input logic [LW-1:0] row, input logic [LW-1:0] col,
                           input logic [LW-1:0] idx);
    iss_q.push_back({wa, ia, row, col, idx});
  endtask

  task automatic exp_tile(input logic [AW-1:0] wa, input logic [AW-1:0] ia,
                          input logic [LW-1:0] row, input logic [LW-1:0] col,
                          input logic [LW-1:0] idx, input logic [7:0] lat,
                          input logic last);
    exp_issue(wa, ia, row, col, idx);
    tile_q.push_back({idx, lat, last});
  endtask

  // ---------------- buffer model ----------------
  initial begin
    int w_cnt, i_cnt;
    w_cnt = 0;
    i_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        wend = 1'b0; iend = 1'b0; w_cnt = 0; i_cnt = 0;
      end else begin
        if (wvld) begin
          wend = 1'b0; w_cnt = w_lat;
        end else if (w_cnt > 0) begin
          w_cnt--;
          if (w_cnt == 0) wend = 1'b1;
        end
        if (ivld) begin
          iend = 1'b0; i_cnt = i_lat;
        end else if (i_cnt > 0) begin
          i_cnt--;
          if (i_cnt == 0) iend = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int last_vld;
    bit prev_done, prev_to;
    logic [35:0] ei;
    logic [12:0] et;
    last_vld  = 0;
    prev_done = 1'b0;
    prev_to   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_done = 1'b0;
        continue;
      end
      if (prev_done) begin
        check("rdy_after_done", 64'(cmd_rdy), 64'd1);
        check("err_after_done", 64'(err), 64'(prev_to));
        prev_done = 1'b0;
      end
      if (wvld) begin
        last_vld = cyc;
        check("ibuff_vld_with_wbuff", 64'(ivld), 64'd1);
        check("err_clear_on_issue", 64'(err), 64'd0);
        if (iss_q.size() == 0) begin
          check("unexpected_ctrl_vld", 64'(wvld), 64'd0);
        end else begin
          ei = iss_q.pop_front();
          check("wbuff_start_addr", 64'(waddr), 64'(ei[35:24]));
          check("ibuff_start_addr", 64'(iaddr), 64'(ei[23:12]));
          check("row_len", 64'(row_len), 64'(ei[11:8]));
          check("col_len", 64'(col_len), 64'(ei[7:4]));
          check("issue_tile_idx", 64'(tile_idx), 64'(ei[3:0]));
        end
      end else begin
        check("ibuff_vld_alone", 64'(ivld), 64'd0);
      end
      if (tile_done) begin
        if (tile_q.size() == 0) begin
          check("unexpected_tile_done", 64'(tile_done), 64'd0);
        end else begin
          et = tile_q.pop_front();
          check("done_tile_idx", 64'(tile_idx), 64'(et[12:9]));
          check("tile_latency", 64'(cyc - last_vld), 64'(et[8:1]));
          check("cmd_done_on_last", 64'(cmd_done), 64'(et[0]));
        end
        if (cmd_done) begin
          prev_done = 1'b1;
          prev_to   = 1'b0;
        end
      end else if (cmd_done) begin
        if (to_q.size() == 0) begin
          check("unexpected_cmd_done", 64'(cmd_done), 64'd0);
        end else begin
          check("timeout_latency", 64'(cyc - last_vld), 64'(to_q.pop_front()));
        end
        prev_done = 1'b1;
        prev_to   = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [AW-1:0] wa, input logic [AW-1:0] ia,
                          input logic [AW-1:0] ws, input logic [AW-1:0] is,
                          input logic [LW-1:0] row, input logic [LW-1:0] col,
                          input logic [LW-1:0] tn, input int wl, input int il);
    int n;
    @(negedge clk);
    cmd_wa = wa; cmd_ia = ia; cmd_ws = ws; cmd_is = is;
    cmd_row = row; cmd_col = col; cmd_tn = tn;
    w_lat = wl; i_lat = il;
    cmd_vld = 1'b1;
    n = 0;
    while (!cmd_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept_in_budget", 64'(cmd_rdy), 64'd1);
    @(posedge clk);
    #1;
    cmd_vld = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_in_budget", 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdy", 64'(cmd_rdy), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_vld", 64'({wvld, ivld}), 64'd0);
    check("rst_pulses", 64'({tile_done, cmd_done}), 64'd0);
    check("rst_addrs", 64'({waddr, iaddr}), 64'd0);
    check("rst_lens_idx", 64'({row_len, col_len, tile_idx}), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;

    // 1: single tile, both ends 5 cycles after ctrl_vld
    exp_tile(12'h100, 12'h200, 4'd3, 4'd3, 4'd0, 8'd5, 1'b1);
    send_cmd(12'h100, 12'h200, 12'h000, 12'h000, 4'd3, 4'd3, 4'd0, 5, 5);
    wait_idle(200);

    // 2: four tiles, ends at 3 / 4 cycles -> tile completes 4 cycles after vld
    exp_tile(12'h100, 12'h200, 4'd2, 4'd5, 4'd0, 8'd4, 1'b0);
    exp_tile(12'h140, 12'h210, 4'd2, 4'd5, 4'd1, 8'd4, 1'b0);
    exp_tile(12'h180, 12'h220, 4'd2, 4'd5, 4'd2, 8'd4, 1'b0);
    exp_tile(12'h1C0, 12'h230, 4'd2, 4'd5, 4'd3, 8'd4, 1'b1);
    send_cmd(12'h100, 12'h200, 12'h040, 12'h010, 4'd2, 4'd5, 4'd3, 3, 4);
    wait_idle(200);

    // 3a: skewed ends, wbuff at +2, ibuff at +9
    exp_tile(12'h300, 12'h400, 4'd1, 4'd1, 4'd0, 8'd9, 1'b1);
    send_cmd(12'h300, 12'h400, 12'h000, 12'h000, 4'd1, 4'd1, 4'd0, 2, 9);
    wait_idle(200);

    // 3b: ends already high in the blanking cycle are ignored -> done at +2
    exp_tile(12'h010, 12'h020, 4'd7, 4'd8, 4'd0, 8'd2, 1'b0);
    exp_tile(12'h011, 12'h022, 4'd7, 4'd8, 4'd1, 8'd2, 1'b1);
    send_cmd(12'h010, 12'h020, 12'h001, 12'h002, 4'd7, 4'd8, 4'd1, 1, 1);
    wait_idle(200);

    // 4: address wrap 0xFF0 + 0x020 -> 0x010
    exp_tile(12'hFF0, 12'h050, 4'd4, 4'd4, 4'd0, 8'd3, 1'b0);
    exp_tile(12'h010, 12'h058, 4'd4, 4'd4, 4'd1, 8'd3, 1'b1);
    send_cmd(12'hFF0, 12'h050, 12'h020, 12'h008, 4'd4, 4'd4, 4'd1, 3, 3);
    wait_idle(200);

    // 5: reset in WAIT of tile 2, then a clean command
    exp_tile(12'h100, 12'h200, 4'd3, 4'd3, 4'd0, 8'd5, 1'b0);
    exp_tile(12'h140, 12'h210, 4'd3, 4'd3, 4'd1, 8'd5, 1'b0);
    exp_issue(12'h180, 12'h220, 4'd3, 4'd3, 4'd2);
    send_cmd(12'h100, 12'h200, 12'h040, 12'h010, 4'd3, 4'd3, 4'd3, 5, 5);
    n = 0;
    while (!(dbg_state == 2'd2 && tile_idx == 4'd2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_wait_tile2", 64'({dbg_state, tile_idx}), 64'({2'd2, 4'd2}));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rdy", 64'(cmd_rdy), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_pulses", 64'({wvld, ivld, tile_done, cmd_done}), 64'd0);
    check("midrst_addrs", 64'({waddr, iaddr}), 64'd0);
    check("midrst_lens_idx", 64'({row_len, col_len, tile_idx}), 64'd0);
    check("midrst_pending", 64'(iss_q.size() + tile_q.size()), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_tile(12'h0A0, 12'h0B0, 4'd6, 4'd2, 4'd0, 8'd5, 1'b1);
    send_cmd(12'h0A0, 12'h0B0, 12'h000, 12'h000, 4'd6, 4'd2, 4'd0, 5, 5);
    wait_idle(200);

    // tile_num all-ones -> 16 tiles, strides 0x011 / 0x001
    for (int k = 0; k < 16; k++) begin
      exp_tile(12'(k * 17), 12'(12'hF00 + k), 4'd15, 4'd0, 4'(k), 8'd2, (k == 15));
    end
    send_cmd(12'h000, 12'hF00, 12'h011, 12'h001, 4'd15, 4'd0, 4'd15, 2, 2);
    wait_idle(400);

`ifdef LSU_MM_ISSUE_CTRL_TIMEOUT_EN
    // 6: ends never arrive -> abort 64 cycles into WAIT, err set until next accept
    exp_issue(12'h123, 12'h321, 4'd1, 4'd2, 4'd0);
    to_q.push_back(8'd64);
    send_cmd(12'h123, 12'h321, 12'h000, 12'h000, 4'd1, 4'd2, 4'd0, 0, 0);
    wait_idle(300);
    check("err_held_in_idle", 64'(err), 64'd1);
    exp_tile(12'h200, 12'h300, 4'd1, 4'd1, 4'd0, 8'd3, 1'b1);
    send_cmd(12'h200, 12'h300, 12'h000, 12'h000, 4'd1, 4'd1, 4'd0, 3, 3);
    wait_idle(200);
    check("err_after_good_cmd", 64'(err), 64'd0);
`endif

    repeat (4) @(negedge clk);
    check("issue_queue_drained", 64'(iss_q.size()), 64'd0);
    check("tile_queue_drained", 64'(tile_q.size()), 64'd0);
    check("timeout_queue_drained", 64'(to_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #400000;
    $display("FAIL global_watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
